// File: rtl/pll_reconfig_ctrl.sv
// Divider-change sequencer for the dynamic rPLL: encodes requests, holds them through
// settle and relock, qualifies lock, retries on timeout and reverts to the last good setting.
module pll_reconfig_ctrl #(
  parameter int unsigned DEF_IDIV     = 1,
  parameter int unsigned DEF_FBDIV    = 1,
  parameter logic [5:0]  DEF_ODSEL    = 6'h38,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned LOCK_STABLE  = 8,
  parameter int unsigned LOCK_TIMEOUT = 27000,
  parameter int unsigned MAX_RETRY    = 2
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_idiv,
  input  logic [6:0] req_fbdiv,
  input  logic [5:0] req_odsel,
  input  logic       pll_lock,
  output logic [5:0] idsel,
  output logic [5:0] fbdsel,
  output logic [5:0] odsel,
  output logic       locked,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned SET_W = (SETTLE_CYC   > 0) ? $clog2(SETTLE_CYC + 1)   : 1;
  localparam int unsigned STB_W = (LOCK_STABLE  > 0) ? $clog2(LOCK_STABLE + 1)  : 1;
  localparam int unsigned TMO_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int unsigned RTY_W = (MAX_RETRY    > 0) ? $clog2(MAX_RETRY + 1)    : 1;

  localparam logic [6:0] DEF_I = 7'(DEF_IDIV);
  localparam logic [6:0] DEF_F = 7'(DEF_FBDIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_WAIT_LOCK,
    S_FAIL
  } state_t;

  // Divider N maps to (64 - N) mod 64; the 7-bit subtraction truncated to 6 bits does the mod.
  function automatic logic [5:0] enc_div(input logic [6:0] div);
    enc_div = 6'(7'd64 - div);
  endfunction

  state_t           state, state_nxt;
  logic [SET_W-1:0] settle_cnt, settle_nxt;
  logic [STB_W-1:0] stable_cnt, stable_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [RTY_W-1:0] retry_cnt, retry_nxt;
  logic             reverting, reverting_nxt;
  logic             user_seq, user_nxt;
  logic [6:0]       cur_idiv, cur_idiv_nxt, cur_fbdiv, cur_fbdiv_nxt;
  logic [5:0]       cur_odsel, cur_odsel_nxt;
  logic [6:0]       good_idiv, good_idiv_nxt, good_fbdiv, good_fbdiv_nxt;
  logic [5:0]       good_odsel, good_odsel_nxt;
  logic [5:0]       idsel_nxt, fbdsel_nxt, odsel_nxt;
  logic             locked_nxt, busy_nxt, ready_nxt, done_nxt, err_nxt;
  logic [1:0]       err_code_nxt;
  logic             accept, req_legal;
  logic             lock_meta, lock_s;

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state      <= S_SETTLE;
      settle_cnt <= '0;
      stable_cnt <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      reverting  <= 1'b0;
      user_seq   <= 1'b0;
      cur_idiv   <= DEF_I;
      cur_fbdiv  <= DEF_F;
      cur_odsel  <= DEF_ODSEL;
      good_idiv  <= DEF_I;
      good_fbdiv <= DEF_F;
      good_odsel <= DEF_ODSEL;
      idsel      <= enc_div(DEF_I);
      fbdsel     <= enc_div(DEF_F);
      odsel      <= DEF_ODSEL;
      locked     <= 1'b0;
      busy       <= 1'b1;
      req_ready  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      stable_cnt <= stable_nxt;
      tmo_cnt    <= tmo_nxt;
      retry_cnt  <= retry_nxt;
      reverting  <= reverting_nxt;
      user_seq   <= user_nxt;
      cur_idiv   <= cur_idiv_nxt;
      cur_fbdiv  <= cur_fbdiv_nxt;
      cur_odsel  <= cur_odsel_nxt;
      good_idiv  <= good_idiv_nxt;
      good_fbdiv <= good_fbdiv_nxt;
      good_odsel <= good_odsel_nxt;
      idsel      <= idsel_nxt;
      fbdsel     <= fbdsel_nxt;
      odsel      <= odsel_nxt;
      locked     <= locked_nxt;
      busy       <= busy_nxt;
      req_ready  <= ready_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      err_code   <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_nxt     = settle_cnt;
    stable_nxt     = stable_cnt;
    tmo_nxt        = tmo_cnt;
    retry_nxt      = retry_cnt;
    reverting_nxt  = reverting;
    user_nxt       = user_seq;
    cur_idiv_nxt   = cur_idiv;
    cur_fbdiv_nxt  = cur_fbdiv;
    cur_odsel_nxt  = cur_odsel;
    good_idiv_nxt  = good_idiv;
    good_fbdiv_nxt = good_fbdiv;
    good_odsel_nxt = good_odsel;
    idsel_nxt      = idsel;
    fbdsel_nxt     = fbdsel;
    odsel_nxt      = odsel;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    err_code_nxt   = err_code;
    accept         = req_valid && req_ready;
    req_legal      = (req_idiv != 7'd0) && (req_idiv <= 7'd64) &&
                     (req_fbdiv != 7'd0) && (req_fbdiv <= 7'd64);

    case (state)
      S_IDLE, S_FAIL: begin
        if (accept && req_legal) begin
          cur_idiv_nxt  = req_idiv;
          cur_fbdiv_nxt = req_fbdiv;
          cur_odsel_nxt = req_odsel;
          retry_nxt     = '0;
          reverting_nxt = 1'b0;
          user_nxt      = 1'b1;
          state_nxt     = S_APPLY;
        end else begin
          if (accept) begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'd1;
          end
          // Lock loss while idle: relock on the current setting, silently
          if (state == S_IDLE && !lock_s) begin
            stable_nxt    = '0;
            tmo_nxt       = '0;
            retry_nxt     = '0;
            reverting_nxt = 1'b0;
            user_nxt      = 1'b0;
            state_nxt     = S_WAIT_LOCK;
          end
        end
      end
      S_APPLY: begin
        idsel_nxt  = enc_div(cur_idiv);
        fbdsel_nxt = enc_div(cur_fbdiv);
        odsel_nxt  = cur_odsel;
        settle_nxt = '0;
        state_nxt  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE_CYC)) begin
          stable_nxt = '0;
          tmo_nxt    = '0;
          state_nxt  = S_WAIT_LOCK;
        end else begin
          settle_nxt = settle_cnt + SET_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (!lock_s)
          stable_nxt = '0;
        else if (stable_cnt != STB_W'(LOCK_STABLE))
          stable_nxt = stable_cnt + STB_W'(1);
        if (tmo_cnt != TMO_W'(LOCK_TIMEOUT))
          tmo_nxt = tmo_cnt + TMO_W'(1);

        // Timeout wins over a stable hit in the same cycle
        if (tmo_cnt == TMO_W'(LOCK_TIMEOUT)) begin
          if (retry_cnt < RTY_W'(MAX_RETRY)) begin
            retry_nxt = retry_cnt + RTY_W'(1);
            state_nxt = S_APPLY;
          end else if (!reverting) begin
            err_nxt       = 1'b1;
            err_code_nxt  = 2'd2;
            cur_idiv_nxt  = good_idiv;
            cur_fbdiv_nxt = good_fbdiv;
            cur_odsel_nxt = good_odsel;
            retry_nxt     = '0;
            reverting_nxt = 1'b1;
            user_nxt      = 1'b0;
            state_nxt     = S_APPLY;
          end else begin
            err_nxt      = 1'b1;
            err_code_nxt = 2'd3;
            user_nxt     = 1'b0;
            state_nxt    = S_FAIL;
          end
        end else if (stable_cnt == STB_W'(LOCK_STABLE)) begin
          good_idiv_nxt  = cur_idiv;
          good_fbdiv_nxt = cur_fbdiv;
          good_odsel_nxt = cur_odsel;
          retry_nxt      = '0;
          reverting_nxt  = 1'b0;
          done_nxt       = user_seq;
          user_nxt       = 1'b0;
          state_nxt      = S_IDLE;
        end
      end
      default: state_nxt = S_FAIL;
    endcase

    locked_nxt = (state_nxt == S_IDLE);
    ready_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_FAIL);
    busy_nxt   = !ready_nxt;
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: request vector table, scoreboard of done/err events,
// and hand-built sequences for reset relock, timeout/revert/fail, lock loss and mid-sequence reset.
module tb_pll_reconfig_ctrl;

  localparam int unsigned T_SETTLE  = 16;
  localparam int unsigned T_STABLE  = 8;
  localparam int unsigned T_TMO     = 100;
  // Reset (or the APPLY edge) to locked: SETTLE_CYC + 2 + LOCK_STABLE edges
  localparam int unsigned LOCK_LAT  = T_SETTLE + 2 + T_STABLE;
  // One failed attempt: APPLY + (SETTLE_CYC+1) settle + (LOCK_TIMEOUT+1) waiting
  localparam int unsigned ATTEMPT   = T_TMO + T_SETTLE + 3;
  localparam logic [17:0] DEF_SEL   = {6'd0, 6'd0, 6'h38};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_idiv = 7'd0;
  logic [6:0] req_fbdiv = 7'd0;
  logic [5:0] req_odsel = 6'd0;
  logic       pll_lock = 1'b1;
  logic [5:0] idsel, fbdsel, odsel;
  logic       locked, busy, done, err;
  logic [1:0] err_code;

  pll_reconfig_ctrl #(
    .DEF_IDIV(64), .DEF_FBDIV(64), .DEF_ODSEL(6'h38),
    .SETTLE_CYC(T_SETTLE), .LOCK_STABLE(T_STABLE), .LOCK_TIMEOUT(T_TMO), .MAX_RETRY(2)
  ) dut (
    .clkin(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_idiv(req_idiv), .req_fbdiv(req_fbdiv), .req_odsel(req_odsel),
    .pll_lock(pll_lock),
    .idsel(idsel), .fbdsel(fbdsel), .odsel(odsel),
    .locked(locked), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_done;
    logic [1:0]  code;
    logic        chk_sel;
    logic [17:0] sel;
  } ev_t;

  typedef struct {
    logic [6:0] idiv;
    logic [6:0] fbdiv;
    logic [5:0] odsel;
    logic       legal;
    logic [5:0] exp_id;
    logic [5:0] exp_fb;
  } vec_t;

  ev_t  sb_q[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample 1 ns after the edge, and retire any done/err pulse
  task automatic tick();
    ev_t ev;
    @(posedge clk);
    #1;
    if (done || err) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got done=%0b err=%0b err_code=%0d, want no event",
                 done, err, err_code);
      end else begin
        ev = sb_q.pop_front();
        check("event_kind", 32'({done, err}), ev.is_done ? 32'd2 : 32'd1);
        if (!ev.is_done) check("event_err_code", 32'(err_code), 32'(ev.code));
        if (ev.chk_sel) check("event_sel", 32'({idsel, fbdsel, odsel}), 32'(ev.sel));
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic send_req(input vec_t v);
    logic [17:0] prev_sel;
    logic        prev_locked;
    int          n;
    wait_ready();
    prev_sel    = {idsel, fbdsel, odsel};
    prev_locked = locked;
    req_idiv    = v.idiv;
    req_fbdiv   = v.fbdiv;
    req_odsel   = v.odsel;
    req_valid   = 1'b1;
    if (v.legal)
      sb_q.push_back('{is_done: 1'b1, code: 2'd0, chk_sel: 1'b1, sel: {v.exp_id, v.exp_fb, v.odsel}});
    else
      sb_q.push_back('{is_done: 1'b0, code: 2'd1, chk_sel: 1'b1, sel: prev_sel});
    tick();
    req_valid = 1'b0;
    if (v.legal) begin
      check("accept_locked", 32'(locked), 32'd0);
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_ready", 32'(req_ready), 32'd0);
      check("accept_sel_hold", 32'({idsel, fbdsel, odsel}), 32'(prev_sel));
      tick();
      check("apply_sel", 32'({idsel, fbdsel, odsel}), 32'({v.exp_id, v.exp_fb, v.odsel}));
      n = 0;
      while (!locked && n < 60) begin
        tick();
        n++;
      end
      check("relock_cycles", 32'(n), 32'(LOCK_LAT));
      check("done_seen", 32'(sb_q.size()), 32'd0);
    end else begin
      check("illegal_err_seen", 32'(sb_q.size()), 32'd0);
      check("illegal_locked", 32'(locked), 32'(prev_locked));
      check("illegal_ready", 32'(req_ready), 32'd1);
      check("illegal_sel", 32'({idsel, fbdsel, odsel}), 32'(prev_sel));
    end
  endtask

  // After reset release: locked low through edge LOCK_LAT-1, high at edge LOCK_LAT
  task automatic reset_relock(input string tag);
    for (int i = 1; i < int'(LOCK_LAT); i++) tick();
    check({tag, "_locked_early"}, 32'(locked), 32'd0);
    tick();
    check({tag, "_locked"}, 32'(locked), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_sel"}, 32'({idsel, fbdsel, odsel}), 32'(DEF_SEL));
  endtask

  initial begin
    logic [17:0] good_sel;
    int          n;

    vecs[0] = '{7'd3,   7'd20, 6'h38, 1'b1, 6'd61, 6'd44};
    vecs[1] = '{7'd0,   7'd5,  6'h11, 1'b0, 6'd0,  6'd0};
    vecs[2] = '{7'd64,  7'd64, 6'h05, 1'b1, 6'd0,  6'd0};
    vecs[3] = '{7'd65,  7'd1,  6'h00, 1'b0, 6'd0,  6'd0};
    vecs[4] = '{7'd1,   7'd1,  6'h3f, 1'b1, 6'd63, 6'd63};
    vecs[5] = '{7'd5,   7'd0,  6'h22, 1'b0, 6'd0,  6'd0};
    vecs[6] = '{7'd64,  7'd65, 6'h10, 1'b0, 6'd0,  6'd0};
    vecs[7] = '{7'd127, 7'd2,  6'h01, 1'b0, 6'd0,  6'd0};
    vecs[8] = '{7'd10,  7'd33, 6'h2a, 1'b1, 6'd54, 6'd31};

    // Reset with lock already high
    tick(); tick(); tick();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_sel", 32'({idsel, fbdsel, odsel}), 32'(DEF_SEL));
    rst_n = 1'b1;
    reset_relock("boot");

    for (int i = 0; i < 9; i++) send_req(vecs[i]);
    check("err_code_hold", 32'(err_code), 32'd1);

    // Lock never returns: three timeouts, revert, three more, then FAIL
    good_sel = {6'd54, 6'd31, 6'h2a};
    wait_ready();
    req_idiv  = 7'd7;
    req_fbdiv = 7'd9;
    req_odsel = 6'h07;
    req_valid = 1'b1;
    sb_q.push_back('{is_done: 1'b0, code: 2'd2, chk_sel: 1'b1, sel: {6'd57, 6'd55, 6'h07}});
    sb_q.push_back('{is_done: 1'b0, code: 2'd3, chk_sel: 1'b1, sel: good_sel});
    tick();
    req_valid = 1'b0;
    pll_lock  = 1'b0;
    n = 0;
    while (sb_q.size() > 1 && n < 1000) begin
      tick();
      n++;
    end
    check("revert_err_cycles", 32'(n), 32'(3 * ATTEMPT));
    tick();
    check("revert_sel", 32'({idsel, fbdsel, odsel}), 32'(good_sel));
    check("revert_busy", 32'(busy), 32'd1);
    n = 1;
    while (sb_q.size() > 0 && n < 1000) begin
      tick();
      n++;
    end
    check("fail_err_cycles", 32'(n), 32'(3 * ATTEMPT));
    check("fail_ready", 32'(req_ready), 32'd1);
    check("fail_locked", 32'(locked), 32'd0);
    check("fail_busy", 32'(busy), 32'd0);
    check("fail_sel", 32'({idsel, fbdsel, odsel}), 32'(good_sel));

    // Recovery from FAIL with a fresh legal request
    pll_lock = 1'b1;
    send_req('{7'd12, 7'd40, 6'h15, 1'b1, 6'd52, 6'd24});
    check("err_code_after_fail", 32'(err_code), 32'd3);

    // One-cycle lock drop while idle: silent relock
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    tick();
    check("drop_locked_still", 32'(locked), 32'd1);
    tick();
    check("drop_locked", 32'(locked), 32'd0);
    check("drop_busy", 32'(busy), 32'd1);
    check("drop_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < int'(T_STABLE); i++) tick();
    check("drop_relock_early", 32'(locked), 32'd0);
    tick();
    check("drop_relock", 32'(locked), 32'd1);
    check("drop_sel", 32'({idsel, fbdsel, odsel}), 32'({6'd52, 6'd24, 6'h15}));
    check("drop_err_code", 32'(err_code), 32'd3);

    // Reset in the middle of a request's SETTLE phase
    wait_ready();
    req_idiv  = 7'd2;
    req_fbdiv = 7'd2;
    req_odsel = 6'h33;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_sel_applied", 32'({idsel, fbdsel, odsel}), 32'({6'd62, 6'd62, 6'h33}));
    rst_n = 1'b0;
    tick();
    check("mid_rst_sel", 32'({idsel, fbdsel, odsel}), 32'(DEF_SEL));
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_locked", 32'(locked), 32'd0);
    check("mid_rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    reset_relock("mid");

    for (int i = 0; i < 10; i++) tick();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
